// File: rtl/adder_sum_accumulator_if.sv
// Sample-in / frame-out handshake bundle between adderWrapper, the accumulator and the reporter.
// The slave side is the accumulator; master is the surrounding producer/consumer.
interface adder_sum_accumulator_if #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 8
);
    logic             in_valid;
    logic [IN_W-1:0]  in_sum;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_sat;

    modport master (
        output in_valid,
        output in_sum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_total,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_total,
        output out_sat
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates FRAME_LEN accepted adderWrapper sums into a saturating frame total and hands the
// total off on a valid/ready port, one frame at a time.
module adder_sum_accumulator #(
    parameter int unsigned IN_W      = 5,
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    adder_sum_accumulator_if.slave bus,
    output logic [15:0] frame_cnt
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [15:0] CNT_LAST = 16'(FRAME_LEN - 1);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_total_q, out_total_d;
    logic             out_sat_q, out_sat_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic             ready_en_q;

    logic             in_ready;
    logic             accept;
    logic             handoff;
    logic [ACC_W:0]   sum_ext;
    logic             ovf;
    logic [ACC_W-1:0] acc_sat;

    always_comb begin
        in_ready = ready_en_q & (state_q == ST_ACCUM);
        accept   = bus.in_valid & in_ready;
        handoff  = (state_q == ST_HOLD) & out_valid_q & bus.out_ready;
        sum_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_sum};
        ovf      = sum_ext[ACC_W];
        acc_sat  = ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_total_d = out_total_q;
        out_sat_d   = out_sat_q;
        frame_cnt_d = frame_cnt_q;

        if (clr) begin
            // Abort drops any pending frame; the last handed-off total stays visible.
            state_d     = ST_ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            acc_d = acc_sat;
            sat_d = sat_q | ovf;
            if (cnt_q == CNT_LAST) begin
                out_total_d = acc_sat;
                out_sat_d   = sat_q | ovf;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (handoff) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            sat_d       = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_sat_q   <= 1'b0;
            frame_cnt_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_sat_q   <= out_sat_d;
            frame_cnt_q <= frame_cnt_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_total = out_total_q;
    assign bus.out_sat   = out_sat_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream stage of adderWrapper: consumes its 5-bit sum stream and accumulates FRAME_LEN accepted samples into a frame total.
- Presents the frame total on a valid/ready output with a sticky saturation flag.
- Feeds the result-reporting/logging stage in the adder simulation subsystem.

Parameters:
IN_W, 5, width of incoming sum (matches adderWrapper out).
ACC_W, 8, accumulator/total width; must be >= IN_W.
FRAME_LEN, 16, samples per frame; legal range 2..2^16.

Ports:
clk  input  1  single clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
clr  input  1  synchronous frame abort; highest priority after reset.
in_valid  input  1  in_sum holds a sample.
in_sum  input  IN_W  unsigned sum from adderWrapper.
in_ready  output  1  stage can accept a sample this cycle.
out_valid  output  1  out_total/out_sat hold a completed frame.
out_ready  input  1  consumer takes the frame this cycle.
out_total  output  ACC_W  saturated unsigned frame total.
out_sat  output  1  the frame saturated at least once.
frame_cnt  output  16  completed frames handed off; wraps 0xFFFF->0.

Behaviour:
- Reset (rst_n=0, async): state=ACCUM, acc=0, sample count=0, sat=0, out_valid=0, out_total=0, out_sat=0, frame_cnt=0, in_ready=0 while rst_n low. After release, in_ready=1 from the first clk edge.
- States: ACCUM and HOLD.
- ACCUM state:
  - in_ready=1.
  - Accept occurs when in_valid and in_ready are both 1.
  - On accept, next = acc + in_sum (ACC_W+1 wide). If next > 2^ACC_W-1, acc=2^ACC_W-1 and sat=1; otherwise acc=next.
  - On accept, count increments.
  - Accept with count==FRAME_LEN-1: out_total <= saturated new acc, out_sat <= sat | this-cycle overflow, out_valid <= 1, state <= HOLD, count <= 0. Latency is one cycle from the last accepting edge to out_valid.
  - No accept: state held.
  - X or unknown on in_sum with in_valid=0 is ignored.
- HOLD state:
  - in_ready=0. in_valid is ignored and upstream must hold its data.
  - out_total and out_sat are stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: out_valid <= 0, acc <= 0, sat <= 0, frame_cnt++, state <= ACCUM. in_ready returns to 1 on the following cycle; there is no same-cycle pass-through.
- out_total and out_sat keep the last frame's value after handoff until the next frame completes.
- clr=1:
  - acc, count and sat are cleared, out_valid=0, state=ACCUM. Any pending frame is dropped and frame_cnt is not incremented.
  - Overrides a simultaneous accept or handoff.
- Saturation: once acc reaches the maximum it stays there for the rest of the frame. Further samples are still accepted and counted.
- rst_n asserted mid-frame or in HOLD: immediate clear per the reset list. No partial frame is emitted.
- in_sum=0 samples count toward FRAME_LEN.

Test Plan:
- Reset: rst_n=0 for 3 cycles with X inputs -> out_valid=0, out_total=0, frame_cnt=0, in_ready=0. Release -> in_ready=1 next edge.
- Nominal frame: in1=5, in2=3 into adderWrapper (sum 8), 16 back-to-back accepts, out_ready=1 -> out_valid for exactly 1 cycle, one cycle after the 16th accept, out_total=128, out_sat=0, frame_cnt=1.
- Saturation: 16 samples of 31 -> out_total=255, out_sat=1. Next frame of 16 samples of 1 -> out_total=16, out_sat=0 (sat cleared).
- Backpressure: frame of sum 8 completes, out_ready=0 for 5 cycles while in_valid=1 with sum 31 -> in_ready=0, out_total stays 128, no samples absorbed. out_ready=1 -> handoff; the next frame starts from 0.
- Gapped input: in_valid toggling 1/0 with sum 2 over 32 cycles -> frame completes after the 16th accept, out_total=32.
- Abort/reset: clr=1 after 7 accepts -> the following 16 accepts of 1 give out_total=16. rst_n=0 in HOLD -> out_valid drops asynchronously, frame_cnt=0.
